// File: rtl/switch_irq_controller.sv
// Debounced-switch interrupt controller: scan prescaler, enable masks, arbitration, clear handshake (SWITCH_IRQ_ROUND_ROBIN_EN selects round-robin).
// Latency: flag -> irqRequest next cycle; irqAck -> clear pulse next cycle -> IDLE the cycle after.
// Backpressure: a presented interrupt is held indefinitely until irqAck; new flags wait for the next IDLE pass.
module switch_irq_controller #(
    parameter int          NR_SWITCHES  = 8,
    parameter logic [15:0] SCAN_DIVIDER = 16'd50000,
    parameter int          ID_WIDTH     = $clog2(NR_SWITCHES)
) (
    input  logic                   clock,
    input  logic                   nReset,
    input  logic [NR_SWITCHES-1:0] pressIrqIn,
    input  logic [NR_SWITCHES-1:0] releaseIrqIn,
    input  logic                   writeEnable,
    input  logic [1:0]             writeAddress,
    input  logic [NR_SWITCHES-1:0] writeData,
    input  logic                   irqAck,
    output logic                   scanTick,
    output logic [NR_SWITCHES-1:0] enablePressIrq,
    output logic [NR_SWITCHES-1:0] enableReleaseIrq,
    output logic [NR_SWITCHES-1:0] resetPressIrq,
    output logic [NR_SWITCHES-1:0] resetReleaseIrq,
    output logic                   irqRequest,
    output logic [ID_WIDTH-1:0]    irqId,
    output logic                   irqIsRelease
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CLEAR   = 2'd2
    } state_t;

    state_t state;

    logic [15:0] prescale_cnt;
    logic [15:0] prescale_nxt;

    logic                   any_pending;
    logic [ID_WIDTH-1:0]    win_id;
    logic                   win_rel;
    logic [NR_SWITCHES-1:0] id_onehot;

`ifdef SWITCH_IRQ_ROUND_ROBIN_EN
    logic [ID_WIDTH-1:0] last_id;
`endif

    always_comb begin
        prescale_nxt = prescale_cnt + 16'd1;
        if (prescale_cnt == SCAN_DIVIDER - 16'd1) begin
            prescale_nxt = 16'd0;
        end
    end

    // The tick is registered off the next count so it lines up with count == SCAN_DIVIDER-1.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            prescale_cnt <= 16'd0;
            scanTick     <= 1'b0;
        end else begin
            prescale_cnt <= prescale_nxt;
            scanTick     <= (prescale_nxt == SCAN_DIVIDER - 16'd1);
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            enablePressIrq   <= '0;
            enableReleaseIrq <= '0;
        end else if (writeEnable) begin
            case (writeAddress)
                2'd0:    enablePressIrq   <= writeData;
                2'd1:    enableReleaseIrq <= writeData;
                default: ;
            endcase
        end
    end

    assign any_pending = |(pressIrqIn | releaseIrqIn);

    // Search order is by channel; within a channel the press flag outranks the release flag.
    always_comb begin
        int  idx;
        int  start_idx;
        logic found;
        idx       = 0;
        start_idx = 0;
        found     = 1'b0;
        win_id    = '0;
        win_rel   = 1'b0;
`ifdef SWITCH_IRQ_ROUND_ROBIN_EN
        if (int'(last_id) < NR_SWITCHES - 1) begin
            start_idx = int'(last_id) + 1;
        end
`endif
        for (int k = 0; k < NR_SWITCHES; k++) begin
            idx = start_idx + k;
            if (idx >= NR_SWITCHES) begin
                idx = idx - NR_SWITCHES;
            end
            if (!found && pressIrqIn[idx]) begin
                found   = 1'b1;
                win_id  = ID_WIDTH'(idx);
                win_rel = 1'b0;
            end else if (!found && releaseIrqIn[idx]) begin
                found   = 1'b1;
                win_id  = ID_WIDTH'(idx);
                win_rel = 1'b1;
            end
        end
    end

    assign id_onehot = {{(NR_SWITCHES-1){1'b0}}, 1'b1} << irqId;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state           <= IDLE;
            irqRequest      <= 1'b0;
            irqId           <= '0;
            irqIsRelease    <= 1'b0;
            resetPressIrq   <= '0;
            resetReleaseIrq <= '0;
`ifdef SWITCH_IRQ_ROUND_ROBIN_EN
            last_id         <= ID_WIDTH'(NR_SWITCHES - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    resetPressIrq   <= '0;
                    resetReleaseIrq <= '0;
                    if (any_pending) begin
                        irqId        <= win_id;
                        irqIsRelease <= win_rel;
                        irqRequest   <= 1'b1;
                        state        <= PENDING;
                    end
                end
                PENDING: begin
                    if (irqAck) begin
                        irqRequest <= 1'b0;
                        if (irqIsRelease) begin
                            resetReleaseIrq <= id_onehot;
                        end else begin
                            resetPressIrq <= id_onehot;
                        end
`ifdef SWITCH_IRQ_ROUND_ROBIN_EN
                        last_id <= irqId;
`endif
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    // The debouncer drops its flag on this pulse, so IDLE never re-sees it.
                    resetPressIrq   <= '0;
                    resetReleaseIrq <= '0;
                    state           <= IDLE;
                end
                default: begin
                    irqRequest      <= 1'b0;
                    resetPressIrq   <= '0;
                    resetReleaseIrq <= '0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_irq_controller.sv
// Bench for switch_irq_controller: directed steps plus randomized flag sets against a priority-rank model.
module tb_switch_irq_controller;

    localparam int N  = 8;
    localparam int SD = 4;

    logic         clock = 1'b0;
    logic         nReset;
    logic [N-1:0] pressIrqIn;
    logic [N-1:0] releaseIrqIn;
    logic         writeEnable;
    logic [1:0]   writeAddress;
    logic [N-1:0] writeData;
    logic         irqAck;
    logic         scanTick;
    logic [N-1:0] enablePressIrq;
    logic [N-1:0] enableReleaseIrq;
    logic [N-1:0] resetPressIrq;
    logic [N-1:0] resetReleaseIrq;
    logic         irqRequest;
    logic [2:0]   irqId;
    logic         irqIsRelease;

    int checks   = 0;
    int failures = 0;
    int last_served;
    logic [N-1:0] m_press_mask;
    logic [N-1:0] m_rel_mask;

    switch_irq_controller #(
        .NR_SWITCHES (N),
        .SCAN_DIVIDER(16'(SD)),
        .ID_WIDTH    (3)
    ) dut (
        .clock           (clock),
        .nReset          (nReset),
        .pressIrqIn      (pressIrqIn),
        .releaseIrqIn    (releaseIrqIn),
        .writeEnable     (writeEnable),
        .writeAddress    (writeAddress),
        .writeData       (writeData),
        .irqAck          (irqAck),
        .scanTick        (scanTick),
        .enablePressIrq  (enablePressIrq),
        .enableReleaseIrq(enableReleaseIrq),
        .resetPressIrq   (resetPressIrq),
        .resetReleaseIrq (resetReleaseIrq),
        .irqRequest      (irqRequest),
        .irqId           (irqId),
        .irqIsRelease    (irqIsRelease)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Winner = pending (channel, kind) with the smallest rank; rank is distance from the search start, press first.
    function automatic int best_key();
        int start;
        int best;
        int best_rank;
        int rank;
        best      = -1;
        best_rank = 1 << 30;
`ifdef SWITCH_IRQ_ROUND_ROBIN_EN
        start = (last_served + 1) % N;
`else
        start = 0;
`endif
        for (int ch = 0; ch < N; ch++) begin
            for (int r = 0; r < 2; r++) begin
                if ((r == 0) ? pressIrqIn[ch] : releaseIrqIn[ch]) begin
                    rank = ((ch - start + N) % N) * 2 + r;
                    if (rank < best_rank) begin
                        best_rank = rank;
                        best      = ch * 2 + r;
                    end
                end
            end
        end
        return best;
    endfunction

    // Entered at a negedge with the DUT idle and flags already driven; leaves at the following IDLE cycle.
    task automatic serve_one(input string tag, input int hold, input logic [N-1:0] inject, output int key);
        int           ch;
        int           rel;
        logic [N-1:0] one;
        key = best_key();
        ch  = key >> 1;
        rel = key & 1;
        one = '0;
        one[ch] = 1'b1;
        step();
        check({tag, ".req"}, 32'(irqRequest), 32'd1);
        check({tag, ".id"}, 32'(irqId), 32'(ch));
        check({tag, ".rel"}, 32'(irqIsRelease), 32'(rel));
        for (int h = 0; h < hold; h++) begin
            pressIrqIn = pressIrqIn | inject;
            step();
            check({tag, ".hold_req"}, 32'(irqRequest), 32'd1);
            check({tag, ".hold_id"}, 32'(irqId), 32'(ch));
        end
        irqAck = 1'b1;
        step();
        irqAck = 1'b0;
        check({tag, ".req_drop"}, 32'(irqRequest), 32'd0);
        check({tag, ".clr_press"}, 32'(resetPressIrq), (rel == 0) ? 32'(one) : 32'd0);
        check({tag, ".clr_rel"}, 32'(resetReleaseIrq), (rel == 1) ? 32'(one) : 32'd0);
        if (rel == 1) releaseIrqIn[ch] = 1'b0;
        else          pressIrqIn[ch]   = 1'b0;
        last_served = ch;
        step();
        check({tag, ".clr_end"}, 32'(resetPressIrq | resetReleaseIrq), 32'd0);
    endtask

    initial begin
        int key;
        int served[$];
        logic [N-1:0] rnd;
        nReset       = 1'b0;
        pressIrqIn   = '0;
        releaseIrqIn = '0;
        writeEnable  = 1'b0;
        writeAddress = 2'd0;
        writeData    = '0;
        irqAck       = 1'b0;
        last_served  = N - 1;
        m_press_mask = '0;
        m_rel_mask   = '0;

        step();
        step();
        check("rst.scan", 32'(scanTick), 32'd0);
        check("rst.req", 32'(irqRequest), 32'd0);
        check("rst.id", 32'(irqId), 32'd0);
        check("rst.isrel", 32'(irqIsRelease), 32'd0);
        check("rst.masks", 32'({enablePressIrq, enableReleaseIrq}), 32'd0);
        check("rst.clr", 32'({resetPressIrq, resetReleaseIrq}), 32'd0);

        // Prescaler: tick on every SD-th cycle after release, single-cycle wide
        nReset = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            check($sformatf("scan.k%0d", k), 32'(scanTick), 32'((k % SD) == SD - 1));
        end
        nReset = 1'b0;
        #1;
        check("scan.async_rst", 32'(scanTick), 32'd0);
        @(negedge clock);
        nReset = 1'b1;
        for (int k = 1; k <= SD; k++) begin
            step();
            check($sformatf("scan.restart%0d", k), 32'(scanTick), 32'((k % SD) == SD - 1));
        end

        // Configuration writes
        writeEnable = 1'b1; writeAddress = 2'd0; writeData = 8'h05;
        step();
        check("cfg.p0", 32'(enablePressIrq), 32'h05);
        check("cfg.r0", 32'(enableReleaseIrq), 32'h00);
        writeAddress = 2'd1; writeData = 8'h80;
        step();
        writeAddress = 2'd2; writeData = 8'hFF;
        step();
        writeAddress = 2'd3; writeData = 8'hAA;
        step();
        writeEnable = 1'b0;
        check("cfg.press", 32'(enablePressIrq), 32'h05);
        check("cfg.release", 32'(enableReleaseIrq), 32'h80);
        check("cfg.no_irq", 32'(irqRequest), 32'd0);
        m_press_mask = 8'h05;
        m_rel_mask   = 8'h80;

        // Single press on channel 3
        pressIrqIn = 8'h08;
        serve_one("p3", 0, '0, key);
        check("p3.key", 32'(key), 32'd6);
        for (int k = 0; k < 3; k++) begin
            step();
            check("p3.no_rereq", 32'(irqRequest), 32'd0);
        end

        // Acknowledge with nothing presented is ignored
        irqAck = 1'b1;
        step();
        step();
        irqAck = 1'b0;
        check("ack_idle.clr", 32'(resetPressIrq | resetReleaseIrq), 32'd0);
        check("ack_idle.req", 32'(irqRequest), 32'd0);

        // Priority order across press/release on channels 2 and 3
        pressIrqIn   = 8'h0C;
        releaseIrqIn = 8'h04;
        served.delete();
        for (int s = 0; s < 3; s++) begin
            serve_one($sformatf("order%0d", s), 0, '0, key);
            served.push_back(key);
        end
`ifdef SWITCH_IRQ_ROUND_ROBIN_EN
        check("order.first", 32'(served[0]), 32'd4);
        check("order.second", 32'(served[1]), 32'd6);
        check("order.third", 32'(served[2]), 32'd5);
`else
        check("order.first", 32'(served[0]), 32'd4);
        check("order.second", 32'(served[1]), 32'd5);
        check("order.third", 32'(served[2]), 32'd6);
`endif
        check("order.drained", 32'(irqRequest), 32'd0);

        // Held without ack while a lower channel raises: latched choice unchanged
        pressIrqIn = 8'h20;
        serve_one("hold5", 4, 8'h01, key);
        check("hold5.key", 32'(key), 32'd10);
        serve_one("hold0", 0, '0, key);
        check("hold0.key", 32'(key), 32'd0);

        // Reset while pending: no clear pulse, flag presented again afterwards
        pressIrqIn = 8'h40;
        step();
        check("rstp.req", 32'(irqRequest), 32'd1);
        check("rstp.id", 32'(irqId), 32'd6);
        nReset = 1'b0;
        #1;
        check("rstp.req_drop", 32'(irqRequest), 32'd0);
        check("rstp.clr", 32'(resetPressIrq | resetReleaseIrq), 32'd0);
        @(negedge clock);
        check("rstp.clr_hold", 32'(resetPressIrq | resetReleaseIrq), 32'd0);
        check("rstp.masks", 32'({enablePressIrq, enableReleaseIrq}), 32'd0);
        nReset       = 1'b1;
        last_served  = N - 1;
        m_press_mask = '0;
        m_rel_mask   = '0;
        serve_one("rstp.re", 0, '0, key);
        check("rstp.key", 32'(key), 32'd12);

        // Randomized flag sets with a concurrent config write
        for (int round = 0; round < 15; round++) begin
            rnd          = 8'($urandom);
            pressIrqIn   = rnd;
            releaseIrqIn = 8'($urandom);
            if (round == 0) releaseIrqIn = ~rnd;
            writeEnable  = 1'b1;
            writeAddress = 2'($urandom_range(0, 3));
            writeData    = 8'($urandom);
            if (writeAddress == 2'd0) m_press_mask = writeData;
            if (writeAddress == 2'd1) m_rel_mask   = writeData;
            for (int s = 0; s < 2 * N && (pressIrqIn | releaseIrqIn) != '0; s++) begin
                serve_one($sformatf("rnd%0d.%0d", round, s), s % 2, '0, key);
                writeEnable = 1'b0;
            end
            writeEnable = 1'b0;
            check($sformatf("rnd%0d.pmask", round), 32'(enablePressIrq), 32'(m_press_mask));
            check($sformatf("rnd%0d.rmask", round), 32'(enableReleaseIrq), 32'(m_rel_mask));
            check($sformatf("rnd%0d.idle", round), 32'(irqRequest), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_irq_controller.md
Name: switch_irq_controller

Overview:
Services a bank of NR_SWITCHES debounced push-button channels; it is the consumer/acknowledge end of their press/release interrupt flags. Generates the shared scanTick, holds the per-channel press/release interrupt enable masks, arbitrates pending flags into a single interrupt request toward the CPU-side logic, and returns a one-cycle clear pulse to the served channel on acknowledge.

Parameters:
NR_SWITCHES, 8, number of debouncer channels (>=2)
SCAN_DIVIDER, 16'd50000, clock cycles per scanTick period (>=2)
ID_WIDTH, $clog2(NR_SWITCHES), width of irqId

Ports:
clock  input  1  system clock; all state updates on rising edge
nReset  input  1  asynchronous, active-low reset
pressIrqIn  input  NR_SWITCHES  per-channel pending press flags from debouncers
releaseIrqIn  input  NR_SWITCHES  per-channel pending release flags from debouncers
writeEnable  input  1  config write strobe
writeAddress  input  2  0=press enable mask, 1=release enable mask, 2/3 ignored
writeData  input  NR_SWITCHES  config write data
irqAck  input  1  CPU-side acknowledge of the presented interrupt
scanTick  output  1  one-cycle sample strobe to all debouncers
enablePressIrq  output  NR_SWITCHES  press enable mask
enableReleaseIrq  output  NR_SWITCHES  release enable mask
resetPressIrq  output  NR_SWITCHES  one-hot one-cycle press-flag clear
resetReleaseIrq  output  NR_SWITCHES  one-hot one-cycle release-flag clear
irqRequest  output  1  interrupt pending toward CPU side
irqId  output  ID_WIDTH  channel index of presented interrupt
irqIsRelease  output  1  0=press event, 1=release event

Behaviour:
- Reset (nReset=0, async): prescaler=0, masks=0, state IDLE, all outputs 0. Reset mid-operation abandons any pending/clear cycle; no clear pulse emitted.
- Prescaler: counts 0..SCAN_DIVIDER-1 every cycle, wraps to 0; scanTick=1 exactly in the cycle count==SCAN_DIVIDER-1 (registered). First tick SCAN_DIVIDER cycles after reset release.
- Config: writeEnable=1 with address 0/1 loads the mask next edge; outputs are the registers directly. Addresses 2/3: no effect. Mask changes never clear already-pending flags; pending flags are serviced regardless of current mask.
- FSM, all outputs registered:
  IDLE: irqRequest=0. If any bit of pressIrqIn|releaseIrqIn set: select winner, latch irqId/irqIsRelease, go PENDING.
  PENDING: irqRequest=1, irqId/irqIsRelease stable. irqAck=1 -> CLEAR, assert resetPressIrq[irqId] or resetReleaseIrq[irqId] (one-hot), irqRequest drops. Without ack stay indefinitely; new flags do not change the latched choice.
  CLEAR: clear pulse high exactly this one cycle; next edge -> IDLE, pulse 0. Debouncer flag is low from the IDLE cycle on, so no double service.
- irqAck outside PENDING: ignored.
- Arbitration (fixed): lowest channel index wins; within one channel press beats release. Release of the same channel served on a later pass.
- Latency: flag seen in cycle N -> irqRequest=1 in N+1; ack in cycle M -> clear pulse in M+1 -> IDLE in M+2; back-to-back pending source -> next irqRequest earliest M+3.
- Write and arbitration in the same cycle are independent.

Optional Feature:
SWITCH_IRQ_ROUND_ROBIN_EN: when defined, arbitration starts search at channel (lastServedId+1) mod NR_SWITCHES (lastServedId resets to NR_SWITCHES-1, so first search starts at 0); press beats release within a channel; lastServedId updated on entering CLEAR. When undefined, fixed lowest-index priority as above, no lastServedId register.

Test Plan:
- SCAN_DIVIDER=4, release reset -> scanTick high cycles 4, 8, 12...; single-cycle each; nReset low mid-count -> count and scanTick 0 immediately.
- Write addr0=0x05, addr1=0x80, addr2=0xFF -> enablePressIrq=0x05, enableReleaseIrq=0x80, no other change.
- pressIrqIn=0x08 -> next cycle irqRequest=1, irqId=3, irqIsRelease=0; irqAck -> resetPressIrq=0x08 for one cycle, then IDLE; flag held low -> no re-request.
- pressIrqIn=0x0C, releaseIrqIn=0x04 fixed priority -> served order (2,press),(2,release),(3,press).
- Same stimulus with SWITCH_IRQ_ROUND_ROBIN_EN after serving channel 2 press with 0x0C still pending on 3 -> next served (3,press) then (2,release).
- nReset asserted while PENDING -> irqRequest=0, no reset* pulse; after release, still-pending flag re-presented.
